// File: rtl/gauss_window_buffer_if.sv
// Pixel-stream / window bus between the raster source, gauss_window_buffer and the Gaussian stage.
// The optional sof line exists only when GAUSS_WINBUF_SOF_EN is defined.
interface gauss_window_buffer_if #(
  parameter int PIX_W = 8
) ();
  logic [PIX_W-1:0]           pix_in;
  logic                       pix_valid;
  logic                       out_stall;
  logic                       pix_ready;
  logic [2:0][2:0][PIX_W-1:0] data_out;
  logic                       win_buf_full;
  logic                       frame_done;
`ifdef GAUSS_WINBUF_SOF_EN
  logic                       sof;

  modport slave (
    input  pix_in, pix_valid, out_stall, sof,
    output pix_ready, data_out, win_buf_full, frame_done
  );
  modport master (
    output pix_in, pix_valid, out_stall, sof,
    input  pix_ready, data_out, win_buf_full, frame_done
  );
`else
  modport slave (
    input  pix_in, pix_valid, out_stall,
    output pix_ready, data_out, win_buf_full, frame_done
  );
  modport master (
    output pix_in, pix_valid, out_stall,
    input  pix_ready, data_out, win_buf_full, frame_done
  );
`endif
endinterface

// File: rtl/gauss_window_buffer.sv
// Two line buffers plus a 3x3 shift window; emits every interior 3x3 neighbourhood of a raster frame.
// Optional macro GAUSS_WINBUF_SOF_EN adds a start-of-frame input that re-anchors the counters at (0,0).
module gauss_window_buffer #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int PIX_W = 8
) (
  input logic                  clk,
  input logic                  n_rst,
  gauss_window_buffer_if.slave bus
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  typedef enum logic [1:0] {FILL, STREAM, DONE} state_e;

  state_e                     state_q, state_d, state_cur;
  logic [CW-1:0]              col_q, col_d, col_cur;
  logic [RW-1:0]              row_q, row_d, row_cur;
  logic [PIX_W-1:0]           lb0_q [IMG_W];
  logic [PIX_W-1:0]           lb1_q [IMG_W];
  logic [2:0][2:0][PIX_W-1:0] win_q, win_d;
  logic [2:0][2:0][PIX_W-1:0] data_out_q;
  logic                       win_buf_full_q, frame_done_q;
  logic                       accept, sof_hit, emit, last_pix;

  assign bus.pix_ready = !bus.out_stall && !n_rst;
  assign accept        = bus.pix_valid && bus.pix_ready;

`ifdef GAUSS_WINBUF_SOF_EN
  assign sof_hit = accept && bus.sof;
`else
  assign sof_hit = 1'b0;
`endif

  // A start-of-frame accept is processed as pixel (0,0) of a fresh frame.
  assign col_cur   = sof_hit ? '0   : col_q;
  assign row_cur   = sof_hit ? '0   : row_q;
  assign state_cur = sof_hit ? FILL : state_q;

  always_comb begin
    state_d  = state_cur;
    col_d    = col_q;
    row_d    = row_q;
    emit     = 1'b0;
    last_pix = 1'b0;
    if (accept) begin
      col_d = col_cur + 1'b1;
      row_d = row_cur;
      if (col_cur == COL_LAST) begin
        col_d = '0;
        row_d = (row_cur == ROW_LAST) ? '0 : row_cur + 1'b1;
      end
    end
    case (state_cur)
      FILL: begin
        if (accept && row_cur == RW'(1) && col_cur == COL_LAST) state_d = STREAM;
      end
      STREAM: begin
        if (accept) begin
          emit = (row_cur >= RW'(2)) && (col_cur >= CW'(2));
          if (row_cur == ROW_LAST && col_cur == COL_LAST) begin
            last_pix = 1'b1;
            state_d  = DONE;
          end
        end
      end
      DONE: begin
        // Counters already wrapped; an accept here is pixel (0,0) of the next frame.
        if (!bus.out_stall) state_d = FILL;
      end
      default: state_d = FILL;
    endcase
  end

  always_comb begin
    win_d = win_q;
    if (accept) begin
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = lb0_q[col_cur];
      win_d[1][2] = lb1_q[col_cur];
      win_d[2][2] = bus.pix_in;
    end
  end

  always_ff @(posedge clk) begin
    if (n_rst) begin
      state_q        <= FILL;
      col_q          <= '0;
      row_q          <= '0;
      win_buf_full_q <= 1'b0;
      frame_done_q   <= 1'b0;
      data_out_q     <= '0;
    end else begin
      state_q        <= state_d;
      col_q          <= col_d;
      row_q          <= row_d;
      win_buf_full_q <= emit;
      frame_done_q   <= last_pix;
      if (emit) data_out_q <= win_d;
    end
  end

  // Window and line-buffer storage carry no reset; stale contents never reach an emit.
  always_ff @(posedge clk) begin
    win_q <= win_d;
    if (accept) begin
      lb0_q[col_cur] <= lb1_q[col_cur];
      lb1_q[col_cur] <= bus.pix_in;
    end
  end

  assign bus.data_out     = data_out_q;
  assign bus.win_buf_full = win_buf_full_q;
  assign bus.frame_done   = frame_done_q;
endmodule

// File: tb/tb_gauss_window_buffer.sv
// Randomized bench for gauss_window_buffer against a frame-level window model.
module tb_gauss_window_buffer;
  localparam int IMG_W = 8;
  localparam int IMG_H = 8;
  localparam int PIX_W = 8;

  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  gauss_window_buffer_if #(.PIX_W(PIX_W)) bus ();

  gauss_window_buffer #(.IMG_W(IMG_W), .IMG_H(IMG_H), .PIX_W(PIX_W)) dut (
    .clk  (clk),
    .n_rst(n_rst),
    .bus  (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [71:0] win9(input int p0, p1, p2, p3, p4, p5, p6, p7, p8);
    logic [2:0][2:0][7:0] w;
    w[0][0] = 8'(p0); w[0][1] = 8'(p1); w[0][2] = 8'(p2);
    w[1][0] = 8'(p3); w[1][1] = 8'(p4); w[1][2] = 8'(p5);
    w[2][0] = 8'(p6); w[2][1] = 8'(p7); w[2][2] = 8'(p8);
    return w;
  endfunction

  // Stimulus stream: every pixel with its raster position inside its frame.
  logic [7:0] stim_pix[$];
  int         stim_r[$];
  int         stim_c[$];
  int         sp = 0;

  bit                   mon_en  = 1'b0;
  bit                   exp_rst = 1'b0;
  bit                   exp_stb = 1'b0;
  bit                   exp_fd  = 1'b0;
  logic [2:0][2:0][7:0] exp_win;
  logic [71:0]          hold_win = '0;
  logic [71:0]          win_log[$];
  int                   n_stb = 0;
  int                   n_fd  = 0;

  task automatic add_frame(input bit rnd, input int offset);
    for (int r = 0; r < IMG_H; r++)
      for (int c = 0; c < IMG_W; c++) begin
        stim_pix.push_back(rnd ? 8'($urandom_range(255)) : 8'(r * IMG_W + c + offset));
        stim_r.push_back(r);
        stim_c.push_back(c);
      end
  endtask

  // Reference: each accepted interior pixel yields, one cycle later, the 3x3 block ending at it.
  initial forever begin
    @(posedge clk);
    exp_stb = 1'b0;
    exp_fd  = 1'b0;
    if (n_rst) begin
      exp_rst = 1'b1;
      sp      = stim_pix.size();
    end else begin
      exp_rst = 1'b0;
      if (bus.pix_valid && bus.pix_ready && sp < stim_pix.size()) begin
        if (stim_r[sp] >= 2 && stim_c[sp] >= 2) begin
          exp_stb = 1'b1;
          for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
              exp_win[i][j] = stim_pix[sp - (2 - i) * IMG_W - (2 - j)];
        end
        exp_fd = (stim_r[sp] == IMG_H - 1) && (stim_c[sp] == IMG_W - 1);
        sp++;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      chk("pix_ready", bus.pix_ready, !bus.out_stall && !n_rst);
      chk("win_buf_full", bus.win_buf_full, exp_stb);
      chk("frame_done", bus.frame_done, exp_fd);
      if (exp_stb) begin
        chk("window", bus.data_out, exp_win);
        hold_win = exp_win;
      end else begin
        if (exp_rst) hold_win = '0;
        chk("data_hold", bus.data_out, hold_win);
      end
      if (bus.win_buf_full) begin
        n_stb++;
        win_log.push_back(bus.data_out);
      end
      if (bus.frame_done) n_fd++;
    end
  end

  // Drives the queued stream until stop_at pixels are consumed; optional 5-cycle stall at stall_at.
  task automatic drive(input int valid_pct, input int stop_at, input int stall_at);
    int  budget = 0;
    bit  stalled = 1'b0;
    while (sp < stop_at && budget < 4000) begin
      if (!stalled && sp == stall_at) begin
        stalled       = 1'b1;
        bus.out_stall = 1'b1;
        bus.pix_valid = 1'b1;
        bus.pix_in    = stim_pix[sp];
        repeat (5) begin @(posedge clk); #1; end
        bus.out_stall = 1'b0;
      end
      bus.pix_valid = ($urandom_range(99) < valid_pct);
      bus.pix_in    = stim_pix[sp];
      @(posedge clk); #1;
      budget++;
    end
    if (budget >= 4000) chk("drive_timeout", 1'b1, 1'b0);
    bus.pix_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_reset();
    n_rst = 1'b1;
    @(posedge clk); #1;
    n_rst = 1'b0;
  endtask

  initial begin
    int b, fb;
    n_rst         = 1'b1;
    bus.pix_valid = 1'b0;
    bus.pix_in    = '0;
    bus.out_stall = 1'b0;
`ifdef GAUSS_WINBUF_SOF_EN
    bus.sof       = 1'b0;
`endif
    @(posedge clk); #1;
    mon_en = 1'b1;
    @(posedge clk); #1;
    n_rst = 1'b0;

    // Ramp frame, continuous valid
    b = n_stb; fb = n_fd;
    add_frame(1'b0, 0);
    drive(100, stim_pix.size(), -1);
    chk("ramp_count", 32'(n_stb - b), 32'd36);
    chk("ramp_fdone", 32'(n_fd - fb), 32'd1);
    chk("ramp_first", win_log[b], win9(0, 1, 2, 8, 9, 10, 16, 17, 18));
    chk("ramp_last", win_log[b + 35], win9(45, 46, 47, 53, 54, 55, 61, 62, 63));

    // Random pixels with ~50% valid gaps
    b = n_stb; fb = n_fd;
    add_frame(1'b1, 0);
    drive(50, stim_pix.size(), -1);
    chk("gaps_count", 32'(n_stb - b), 32'd36);
    chk("gaps_fdone", 32'(n_fd - fb), 32'd1);

    // Stall for 5 cycles in the middle of row 4
    b = n_stb; fb = n_fd;
    add_frame(1'b1, 0);
    drive(100, stim_pix.size(), sp + 4 * IMG_W + 4);
    chk("stall_count", 32'(n_stb - b), 32'd36);
    chk("stall_fdone", 32'(n_fd - fb), 32'd1);

    // Reset after 30 pixels, then a fresh frame
    add_frame(1'b0, 0);
    drive(100, sp + 30, -1);
    bus.pix_valid = 1'b1;
    pulse_reset();
    bus.pix_valid = 1'b0;
    b = n_stb; fb = n_fd;
    add_frame(1'b0, 0);
    drive(100, stim_pix.size(), -1);
    chk("rst_count", 32'(n_stb - b), 32'd36);
    chk("rst_first", win_log[b], win9(0, 1, 2, 8, 9, 10, 16, 17, 18));

    // Back-to-back frames, second offset by 100
    b = n_stb; fb = n_fd;
    add_frame(1'b0, 0);
    add_frame(1'b0, 100);
    drive(100, stim_pix.size(), -1);
    chk("b2b_count", 32'(n_stb - b), 32'd72);
    chk("b2b_fdone", 32'(n_fd - fb), 32'd2);
    chk("b2b_37th", win_log[b + 36], win9(100, 101, 102, 108, 109, 110, 116, 117, 118));

    // Random back-to-back frames with gaps
    b = n_stb; fb = n_fd;
    add_frame(1'b1, 0);
    add_frame(1'b1, 0);
    drive(70, stim_pix.size(), -1);
    chk("rnd2_count", 32'(n_stb - b), 32'd72);
    chk("rnd2_fdone", 32'(n_fd - fb), 32'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
